// File: rtl/apb_slave_wait_if.sv
// APB4 bus bundle between a system master and the apb_slave_wait front-end.
interface apb_slave_wait_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32
);
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_W-1:0]     paddr;
    logic [DATA_W-1:0]     pwdata;
    logic [DATA_W/8-1:0]   pstrb;
    logic                  pready;
    logic                  pslverr;
    logic [DATA_W-1:0]     prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, pslverr, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, pslverr, prdata
    );
endinterface

// File: rtl/apb_slave_wait.sv
// APB4 slave front-end with programmable wait states, driving one-cycle strobes into a register block.
// Optional APB_SLV_PSTRB_EN: honour pstrb byte lanes (otherwise every write is full width).
module apb_slave_wait #(
    parameter int ADDR_W   = 12,
    parameter int DATA_W   = 32,
    parameter int WAIT_CYC = 0
) (
    input  logic                  pclk,
    input  logic                  presetn,
    apb_slave_wait_if.slave       apb,
    output logic [ADDR_W-1:0]     reg_addr,
    output logic                  reg_we,
    output logic                  reg_re,
    output logic [DATA_W-1:0]     reg_wdata,
    output logic [DATA_W/8-1:0]   reg_wstrb,
    input  logic [DATA_W-1:0]     reg_rdata,
    input  logic                  reg_err
);
    localparam int STRB_W = DATA_W / 8;
    localparam int LSB_W  = $clog2(STRB_W);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   addr_reg;
    logic                pwrite_reg;
    logic                err_reg;
    logic [3:0]          cnt_reg;
    logic [DATA_W-1:0]   wdata_reg;
    logic [STRB_W-1:0]   wstrb_reg;
    logic [DATA_W-1:0]   prdata_reg;

    logic                setup;
    logic                misaligned;
    logic                completion;
    logic                pready_int;
    logic [DATA_W-1:0]   wdata_in;
    logic [STRB_W-1:0]   wstrb_in;

    assign setup = (state_reg == IDLE) & apb.psel & ~apb.penable;

    generate
        if (LSB_W == 0) begin : g_no_align
            assign misaligned = 1'b0;
        end else begin : g_align
            assign misaligned = |apb.paddr[LSB_W-1:0];
        end
    endgenerate

`ifdef APB_SLV_PSTRB_EN
    // Disabled lanes are zeroed so the register block never sees stale bytes.
    assign wstrb_in = apb.pstrb;
    generate
        for (genvar gi = 0; gi < STRB_W; gi++) begin : g_lane
            assign wdata_in[gi*8 +: 8] = apb.pstrb[gi] ? apb.pwdata[gi*8 +: 8] : 8'h00;
        end
    endgenerate
`else
    logic unused_pstrb;
    assign unused_pstrb = ^apb.pstrb;
    assign wstrb_in     = apb.pwrite ? {STRB_W{1'b1}} : {STRB_W{1'b0}};
    assign wdata_in     = apb.pwdata;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        pready_int = 1'b0;
        completion = 1'b0;
        reg_re     = 1'b0;
        case (state_reg)
            IDLE: begin
                // Read strobe fires even for bad addresses; data is sampled here, not at completion.
                reg_re = apb.psel & ~apb.penable & ~apb.pwrite;
                if (apb.psel && !apb.penable) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                pready_int = (cnt_reg == 4'd0);
                if (!apb.psel) begin
                    state_next = IDLE;
                end else if (pready_int && apb.penable) begin
                    completion = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_reg   <= '0;
            pwrite_reg <= 1'b0;
            err_reg    <= 1'b0;
            cnt_reg    <= 4'd0;
            wdata_reg  <= '0;
            wstrb_reg  <= '0;
            prdata_reg <= '0;
        end else begin
            if (setup) begin
                addr_reg   <= apb.paddr;
                pwrite_reg <= apb.pwrite;
                err_reg    <= reg_err | misaligned;
                cnt_reg    <= 4'(WAIT_CYC);
                wdata_reg  <= wdata_in;
                wstrb_reg  <= wstrb_in;
            end else if (state_reg == ACCESS && cnt_reg != 4'd0) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (reg_re) begin
                prdata_reg <= reg_rdata;
            end
        end
    end

    assign reg_addr    = (state_reg == IDLE) ? apb.paddr : addr_reg;
    assign reg_wdata   = wdata_reg;
    assign reg_wstrb   = wstrb_reg;
    assign reg_we      = completion & pwrite_reg & ~err_reg & (|wstrb_reg);
    assign apb.pready  = pready_int;
    assign apb.pslverr = pready_int & err_reg;
    assign apb.prdata  = (pready_int & ~pwrite_reg & ~err_reg) ? prdata_reg : '0;
endmodule

// File: tb/tb_apb_slave_wait.sv
// Scoreboard bench for apb_slave_wait: three instances with WAIT_CYC 0, 3 and 1 share one driver.
module tb_apb_slave_wait;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    always #5 pclk = ~pclk;

    logic [2:0]  sel_v;
    logic        penable_t, pwrite_t;
    logic [11:0] paddr_t;
    logic [31:0] pwdata_t, rdata_t;
    logic [3:0]  pstrb_t;

    logic [2:0]  pready_v, pslverr_v, reg_we_v, reg_re_v;
    logic [31:0] prdata_v    [3];
    logic [11:0] reg_addr_v  [3];
    logic [31:0] reg_wdata_v [3];
    logic [3:0]  reg_wstrb_v [3];

    int wc_tab [3] = '{0, 3, 1};
    int re_cnt [3] = '{0, 0, 0};
    int n_checks = 0;
    int n_fail   = 0;

    logic [32:0] rq [$];   // {pslverr, prdata}
    logic [49:0] wq [$];   // {dut, addr, wdata, wstrb}
    logic [49:0] w;

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_dut
            apb_slave_wait_if #(.ADDR_W(12), .DATA_W(32)) bus ();
            assign bus.psel    = sel_v[gi];
            assign bus.penable = penable_t & sel_v[gi];
            assign bus.pwrite  = pwrite_t;
            assign bus.paddr   = paddr_t;
            assign bus.pwdata  = pwdata_t;
            assign bus.pstrb   = pstrb_t;
            assign pready_v[gi]  = bus.pready;
            assign pslverr_v[gi] = bus.pslverr;
            assign prdata_v[gi]  = bus.prdata;

            apb_slave_wait #(.ADDR_W(12), .DATA_W(32), .WAIT_CYC(gi == 0 ? 0 : (gi == 1 ? 3 : 1))) dut (
                .pclk      (pclk),
                .presetn   (presetn),
                .apb       (bus.slave),
                .reg_addr  (reg_addr_v[gi]),
                .reg_we    (reg_we_v[gi]),
                .reg_re    (reg_re_v[gi]),
                .reg_wdata (reg_wdata_v[gi]),
                .reg_wstrb (reg_wstrb_v[gi]),
                .reg_rdata (rdata_t),
                .reg_err   (reg_addr_v[gi][11])
            );
        end
    endgenerate

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lane_mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) r[8*b +: 8] = s[b] ? d[8*b +: 8] : 8'h00;
        return r;
    endfunction

    // Register-side monitor: every reg_we must match the oldest expected write.
    always @(negedge pclk) begin
        for (int i = 0; i < 3; i++) begin
            if (reg_re_v[i]) re_cnt[i]++;
            if (reg_we_v[i]) begin
                if (wq.size() == 0) begin
                    check_eq("we_unexp", i, 99);
                end else begin
                    w = wq.pop_front();
                    check_eq("we_dut", i, w[49:48]);
                    check_eq("we_addr", reg_addr_v[i], w[47:36]);
                    check_eq("we_wdata", reg_wdata_v[i], w[35:4]);
                    check_eq("we_wstrb", reg_wstrb_v[i], w[3:0]);
                end
            end
        end
    end

    // Entered and left at posedge+1; consecutive calls are back-to-back.
    task automatic apb_xfer(input int d, input bit wr, input logic [11:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb);
        logic        err;
        logic [3:0]  es;
        logic [31:0] ew;
        logic [32:0] r;
        int          k, re0;
        err = (addr[1:0] != 2'b00) | addr[11];
`ifdef APB_SLV_PSTRB_EN
        es = strb;
        ew = lane_mask(wdata, strb);
`else
        es = 4'hF;
        ew = wdata;
`endif
        rq.push_back({err, (wr || err) ? 32'h0 : rdata_t});
        if (wr && !err && es != 4'h0) wq.push_back({2'(d), addr, ew, es});
        re0 = re_cnt[d];
        sel_v = 3'b000;
        sel_v[d] = 1'b1;
        penable_t = 1'b0;
        pwrite_t = wr;
        paddr_t = addr;
        pwdata_t = wdata;
        pstrb_t = strb;
        @(posedge pclk); #1;
        penable_t = 1'b1;
        pwdata_t = ~wdata;
        pstrb_t = ~strb;
        rdata_t = ~rdata_t;
        k = 0;
        do begin
            @(negedge pclk);
            k++;
        end while (!pready_v[d] && k < 40);
        check_eq("latency", k, wc_tab[d] + 1);
        r = rq.pop_front();
        check_eq("pslverr", pslverr_v[d], r[32]);
        check_eq("prdata", prdata_v[d], r[31:0]);
        $display("xfer dut=%0d wr=%0d addr=0x%03h wdata=0x%08h strb=0x%0h err=%0d access_cycles=%0d",
                 d, wr, addr, wdata, strb, err, k);
        @(posedge pclk); #1;
        sel_v = 3'b000;
        penable_t = 1'b0;
        check_eq("we_missing", wq.size(), 0);
        check_eq("re_pulses", re_cnt[d] - re0, wr ? 0 : 1);
    endtask

    task automatic idle_cycle();
        @(posedge pclk); #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] ra;
        sel_v = 3'b000;
        penable_t = 1'b0;
        pwrite_t = 1'b0;
        paddr_t = 12'h123;
        pwdata_t = 32'h0;
        pstrb_t = 4'h0;
        rdata_t = 32'h0;
        #12;
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_pready", pready_v[i], 0);
            check_eq("rst_pslverr", pslverr_v[i], 0);
            check_eq("rst_prdata", prdata_v[i], 0);
            check_eq("rst_we_re", {reg_we_v[i], reg_re_v[i]}, 0);
            check_eq("rst_wdata", reg_wdata_v[i], 0);
            check_eq("rst_wstrb", reg_wstrb_v[i], 0);
            check_eq("rst_addr", reg_addr_v[i], paddr_t);
        end
        @(posedge pclk); #1;
        presetn = 1'b1;
        idle_cycle();

        apb_xfer(0, 1, 12'h040, 32'hDEADBEEF, 4'hF);
        idle_cycle();
        rdata_t = 32'h12345678;
        apb_xfer(1, 0, 12'h010, 32'h0, 4'h0);
        idle_cycle();
        rdata_t = 32'hCAFEF00D;
        apb_xfer(0, 0, 12'h012, 32'h0, 4'h0);
        apb_xfer(0, 1, 12'h844, 32'h11112222, 4'hF);
        idle_cycle();
        apb_xfer(0, 1, 12'h050, 32'hAABBCCDD, 4'h5);
        apb_xfer(1, 1, 12'h054, 32'h55667788, 4'h0);
        idle_cycle();
        apb_xfer(2, 1, 12'h060, 32'h01020304, 4'hF);
        rdata_t = 32'h9ABCDEF0;
        apb_xfer(2, 0, 12'h064, 32'h0, 4'h0);
        idle_cycle();

        // Abort during a wait state: master drops psel, slave must go quiet and return to IDLE.
        sel_v = 3'b010; penable_t = 1'b0; pwrite_t = 1'b1;
        paddr_t = 12'h080; pwdata_t = 32'hFEEDFACE; pstrb_t = 4'hF;
        @(posedge pclk); #1;
        penable_t = 1'b1;
        @(negedge pclk);
        check_eq("abort_pready_wait", pready_v[1], 0);
        @(posedge pclk); #1;
        sel_v = 3'b000; penable_t = 1'b0; paddr_t = 12'h0C0;
        @(negedge pclk);
        check_eq("abort_pready", pready_v[1], 0);
        @(negedge pclk);
        check_eq("abort_idle_addr", reg_addr_v[1], paddr_t);
        @(posedge pclk); #1;
        rdata_t = 32'h0BADCAFE;
        apb_xfer(1, 0, 12'h018, 32'h0, 4'h0);

        // Reset asserted mid-transfer.
        sel_v = 3'b010; penable_t = 1'b0; pwrite_t = 1'b1;
        paddr_t = 12'h070; pwdata_t = 32'h13572468; pstrb_t = 4'hF;
        @(posedge pclk); #1;
        penable_t = 1'b1;
        @(posedge pclk); #1;
        presetn = 1'b0;
        #1;
        check_eq("mid_rst_pready", pready_v[1], 0);
        check_eq("mid_rst_pslverr", pslverr_v[1], 0);
        check_eq("mid_rst_prdata", prdata_v[1], 0);
        check_eq("mid_rst_we", reg_we_v[1], 0);
        check_eq("mid_rst_wdata", reg_wdata_v[1], 0);
        check_eq("mid_rst_wstrb", reg_wstrb_v[1], 0);
        check_eq("mid_rst_addr", reg_addr_v[1], paddr_t);
        sel_v = 3'b000; penable_t = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        idle_cycle();
        apb_xfer(1, 1, 12'h074, 32'h24681357, 4'hF);

        for (int n = 0; n < 12; n++) begin
            ra = 12'($urandom) & 12'h7FC;
            if ($urandom_range(0, 3) == 0) ra[11] = 1'b1;
            if ($urandom_range(0, 3) == 0) ra[0] = 1'b1;
            rdata_t = $urandom;
            apb_xfer(int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), ra, $urandom, 4'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycle();
        end
        idle_cycle();
        idle_cycle();
        check_eq("wq_drained", wq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
